hazard_controller: RTL and testbench

Central pipeline sequencer for the 5-stage core: computes the stall (enable) and flush (clear) controls for every inter-stage register, including fetch_to_decode, and the E-stage forwarding selects. It resolves load-use and branch hazards, and runs a small FSM that freezes the pipeline while a multi-cycle data-memory access in M is outstanding. It sits beside the datapath, is driven by decoded register indices and stage control bits, and feeds the stage registers' enable (active-low stall) and synchronous clear inputs.

---
 rtl/hazard_controller.sv | 155 +++++++++++++++
 tb/tb_hazard_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use/branch stall-flush control, E-stage forwarding, memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        ResultSrcE0,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
);

  typedef enum logic {IDLE = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_stall;
  logic       load_use;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = 8'd0;
        if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abandon the access: release the pipeline and latch the error.
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_use = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    mem_stall = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:     mem_stall = MemReqM && !MemReadyM;
        MEM_WAIT: mem_stall = !MemReadyM && (wait_cnt_q != WAIT_LAST);
        default:  mem_stall = 1'b0;
      endcase
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  logic [1:0][4:0] rs_e;
  assign rs_e = {Rs2E, Rs1E};

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [1:0] sel;
    always_comb begin
      sel = 2'b00;
      if (!rst) begin
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]))      sel = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi])) sel = 2'b01;
      end
    end
  end

  assign ForwardAE = g_fwd[0].sel;
  assign ForwardBE = g_fwd[1].sel;
  assign MemErr    = mem_err_q && !rst;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (StallF)           stall_cycles_q <= stall_cycles_q + 32'd1;
      if (FlushD || FlushE) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`else
  assign StallCycles = 32'd0;
  assign FlushCount  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: per-cycle reference model plus literal spot checks.
module tb_hazard_controller;
  localparam int TO = 4;
`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCycles, FlushCount;

  hazard_controller #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_model(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Reference model: m_wait < 0 means no access is outstanding, else cycles already waited.
  bit          m_valid = 1'b0;
  int          m_wait  = -1;
  bit          m_err   = 1'b0;
  logic [31:0] m_sc    = 32'd0;
  logic [31:0] m_fc    = 32'd0;

  always @(negedge clk) begin : cmp
    bit hold, lu;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_err;
    logic [1:0] e_fa, e_fb;
    lu   = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    hold = (m_wait < 0) ? (MemReqM && !MemReadyM) : (!MemReadyM && m_wait < TO - 1);
    e_sf = hold || (!PCSrcE && lu);
    e_sd = e_sf;
    e_se = hold;
    e_sm = hold;
    e_fw = hold;
    e_fd = !hold && PCSrcE;
    e_fe = !hold && (PCSrcE || lu);
    e_fa = fwd_model(Rs1E);
    e_fb = fwd_model(Rs2E);
    e_err = m_err;
    if (rst) begin
      {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_err} = '0;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end
    if (m_valid) begin
      chk("StallF", 32'(StallF), 32'(e_sf));
      chk("StallD", 32'(StallD), 32'(e_sd));
      chk("StallE", 32'(StallE), 32'(e_se));
      chk("StallM", 32'(StallM), 32'(e_sm));
      chk("FlushD", 32'(FlushD), 32'(e_fd));
      chk("FlushE", 32'(FlushE), 32'(e_fe));
      chk("FlushW", 32'(FlushW), 32'(e_fw));
      chk("ForwardAE", 32'(ForwardAE), 32'(e_fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(e_fb));
      chk("MemErr", 32'(MemErr), 32'(e_err));
      chk("StallCycles", StallCycles, PERF ? m_sc : 32'd0);
      chk("FlushCount", FlushCount, PERF ? m_fc : 32'd0);
    end
    if (rst) begin
      m_valid = 1'b1;
      m_wait  = -1;
      m_err   = 1'b0;
      m_sc    = 32'd0;
      m_fc    = 32'd0;
    end else begin
      if (e_sf)         m_sc = m_sc + 32'd1;
      if (e_fd || e_fe) m_fc = m_fc + 32'd1;
      if (m_wait < 0) begin
        if (hold) m_wait = 0;
      end else if (MemReadyM) begin
        m_wait = -1;
      end else if (m_wait == TO - 1) begin
        m_wait = -1;
        m_err  = 1'b1;
      end else begin
        m_wait++;
      end
    end
  end

  task automatic clear_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; MemReqM = 1'b1; PCSrcE = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3;
    step(); step(); settle();
    $display("step reset with hazards on inputs");
    chk("rst_StallF", 32'(StallF), 32'd0);
    chk("rst_FlushD", 32'(FlushD), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_ForwardAE", 32'(ForwardAE), 32'd0);

    rst = 1'b0; clear_in();
    step();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; settle();
    $display("step load-use on Rs1D");
    chk("lu_StallF", 32'(StallF), 32'd1);
    chk("lu_StallD", 32'(StallD), 32'd1);
    chk("lu_FlushE", 32'(FlushE), 32'd1);
    chk("lu_StallE", 32'(StallE), 32'd0);
    step(); clear_in(); settle();
    $display("step bubble after load-use");
    chk("bubble_StallF", 32'(StallF), 32'd0);
    chk("bubble_FlushE", 32'(FlushE), 32'd0);
    step(); ResultSrcE0 = 1'b1; RdE = 5'd9; Rs2D = 5'd9; settle();
    $display("step load-use on Rs2D");
    chk("lu2_StallD", 32'(StallD), 32'd1);
    step(); clear_in(); ResultSrcE0 = 1'b1; settle();
    $display("step load to x0");
    chk("lu0_StallF", 32'(StallF), 32'd0);

    step(); clear_in();
    RegWriteM = 1'b1; RdM = 5'd7; RegWriteW = 1'b1; RdW = 5'd7; Rs1E = 5'd7; settle();
    $display("step forward M over W");
    chk("fwd_M", 32'(ForwardAE), 32'd2);
    step(); RegWriteM = 1'b0; settle();
    $display("step forward W");
    chk("fwd_W", 32'(ForwardAE), 32'd1);
    step(); RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; settle();
    $display("step forward from x0 suppressed");
    chk("fwd_x0", 32'(ForwardAE), 32'd0);
    step(); clear_in(); RegWriteW = 1'b1; RdW = 5'd12; Rs2E = 5'd12; settle();
    $display("step forward B from W");
    chk("fwdB_W", 32'(ForwardBE), 32'd1);

    step(); clear_in();
    PCSrcE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; settle();
    $display("step branch with load-use");
    chk("br_FlushD", 32'(FlushD), 32'd1);
    chk("br_FlushE", 32'(FlushE), 32'd1);
    chk("br_StallF", 32'(StallF), 32'd0);
    chk("br_StallD", 32'(StallD), 32'd0);

    step(); clear_in(); MemReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      $display("step memory wait cycle %0d", i);
      chk("mw_StallM", 32'(StallM), 32'd1);
      chk("mw_FlushW", 32'(FlushW), 32'd1);
      chk("mw_FlushD", 32'(FlushD), 32'd0);
      step();
    end
    MemReadyM = 1'b1; settle();
    $display("step memory ready release");
    chk("rel_StallF", 32'(StallF), 32'd0);
    chk("rel_FlushD", 32'(FlushD), 32'd1);
    chk("rel_FlushE", 32'(FlushE), 32'd1);

    step(); clear_in(); MemReqM = 1'b1;
    for (int i = 0; i < TO; i++) begin
      settle();
      $display("step timeout wait cycle %0d", i);
      chk("to_StallE", 32'(StallE), 32'd1);
      step();
    end
    settle();
    $display("step timeout release");
    chk("to_rel_StallE", 32'(StallE), 32'd0);
    chk("to_rel_MemErr", 32'(MemErr), 32'd0);
    step(); MemReqM = 1'b0; settle();
    $display("step error sticky");
    chk("to_MemErr", 32'(MemErr), 32'd1);
    step(); step(); settle();
    chk("to_MemErr_hold", 32'(MemErr), 32'd1);

    step(); MemReqM = 1'b1; settle();
    $display("step reset during memory wait");
    chk("rw_StallF", 32'(StallF), 32'd1);
    step(); rst = 1'b1; settle();
    chk("rw_rst_StallF", 32'(StallF), 32'd0);
    chk("rw_rst_MemErr", 32'(MemErr), 32'd0);
    step(); rst = 1'b0; MemReqM = 1'b0; settle();
    chk("rw_after_StallF", 32'(StallF), 32'd0);
    chk("rw_after_MemErr", 32'(MemErr), 32'd0);

    step(); rst = 1'b1;
    step(); rst = 1'b0; clear_in(); ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
    repeat (10) step();
    clear_in(); settle();
    $display("step performance counters after 10 stall cycles");
    chk("perf_StallCycles", StallCycles, PERF ? 32'd10 : 32'd0);
    chk("perf_FlushCount", FlushCount, PERF ? 32'd10 : 32'd0);
    step(); rst = 1'b1;
    step(); settle();
    chk("perf_rst_StallCycles", StallCycles, 32'd0);
    rst = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
